// File: rtl/rsa_pkg.sv
// Shared RSA definitions: command codes, exponentiation controller states
// and small arithmetic helpers used across the RSA datapath.
package rsa_pkg;

   typedef enum logic [1:0] {
      RSA_CMD_NOP,
      RSA_CMD_ENC,
      RSA_CMD_DEC,
      RSA_CMD_SIGN
   } rsa_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_LOOP,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } mx_state_t;

   function automatic logic [31:0] sat_add32(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/montgomery.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// One operand bit per cycle, single final conditional subtraction.
module montgomery #(
   parameter int WIDTH = 1024
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] a, b, m;
   logic [WIDTH:0]   s, s_next;
   logic [WIDTH+1:0] s_add, s_red;
   logic [WIDTH-1:0] s_fin;
   logic [CW-1:0]    cnt;
   logic             run;

   // s stays below 2m, so s + b + m never exceeds WIDTH+2 bits
   always_comb begin
      s_add  = {1'b0, s} + (a[0] ? {2'b00, b} : '0);
      s_red  = s_add[0] ? s_add + {2'b00, m} : s_add;
      s_next = (WIDTH+1)'(s_red >> 1);
      s_fin  = (s_next >= {1'b0, m}) ? WIDTH'(s_next - {1'b0, m})
                                     : WIDTH'(s_next);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         a      <= '0;
         b      <= '0;
         m      <= '0;
         s      <= '0;
         cnt    <= '0;
         run    <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         if (start && !run) begin
            a   <= in_a;
            b   <= in_b;
            m   <= in_m;
            s   <= '0;
            cnt <= '0;
            run <= 1'b1;
         end else if (run) begin
            a   <= a >> 1;
            s   <= s_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               run    <= 1'b0;
               done   <= 1'b1;
               result <= s_fin;
            end
         end
      end
   end

endmodule

// File: rtl/mod_exp_par.sv
// Right-to-left binary modular exponentiation with the square and the
// multiply running concurrently on two Montgomery instances.
module mod_exp_par
   import rsa_pkg::*;
#(
   parameter int WIDTH     = 1024,
   parameter int EXP_WIDTH = 1024,
   parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     x,
   input  logic [EXP_WIDTH-1:0] e,
   input  logic [LEN_W-1:0]     e_len,
   input  logic [WIDTH-1:0]     n,
   input  logic [WIDTH-1:0]     r_n,
   input  logic [WIDTH-1:0]     r2_n,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic [31:0]          cycles
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   mx_state_t            state;
   logic [EXP_WIDTH-1:0] e_q;
   logic [LEN_W-1:0]     rem, len_eff;
   logic [WIDTH-1:0]     n_q, rn_q, p_q, a_q, a_next;
   logic [WIDTH-1:0]     sq_a, sq_b, mul_a, mul_b, sq_res, mul_res;
   logic                 sq_go, mul_go, sq_done, mul_done;
   logic                 sq_ok, mul_ok, both;
   logic [31:0]          cnt;

   always_comb begin
      if (32'(e_len) > EXP_WIDTH) len_eff = LEN_W'(EXP_WIDTH);
      else                        len_eff = e_len;
      both   = (sq_ok | sq_done) & (mul_ok | mul_done);
      a_next = mul_done ? mul_res : a_q;
   end

   montgomery #(.WIDTH(WIDTH)) u_sq (
      .clk    (clk),
      .resetn (resetn),
      .start  (sq_go),
      .in_a   (sq_a),
      .in_b   (sq_b),
      .in_m   (n_q),
      .result (sq_res),
      .done   (sq_done)
   );

   montgomery #(.WIDTH(WIDTH)) u_mul (
      .clk    (clk),
      .resetn (resetn),
      .start  (mul_go),
      .in_a   (mul_a),
      .in_b   (mul_b),
      .in_m   (n_q),
      .result (mul_res),
      .done   (mul_done)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cycles <= '0;
         cnt    <= '0;
         e_q    <= '0;
         rem    <= '0;
         n_q    <= '0;
         rn_q   <= '0;
         p_q    <= '0;
         a_q    <= '0;
         sq_a   <= '0;
         sq_b   <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         sq_go  <= 1'b0;
         mul_go <= 1'b0;
         sq_ok  <= 1'b0;
         mul_ok <= 1'b0;
      end else begin
         sq_go  <= 1'b0;
         mul_go <= 1'b0;
         done   <= 1'b0;
         if (state != ST_IDLE) cnt <= sat_add32(cnt, 32'd1);
         unique case (state)
            ST_IDLE: if (start) begin
               e_q   <= e;
               rem   <= len_eff;
               n_q   <= n;
               rn_q  <= r_n;
               sq_a  <= x;
               sq_b  <= r2_n;
               sq_go <= 1'b1;
               busy  <= 1'b1;
               cnt   <= 32'd1;
               state <= ST_PRE;
            end
            ST_PRE: if (sq_done) begin
               p_q <= sq_res;
               a_q <= rn_q;
               if (rem == '0) begin
                  mul_a  <= rn_q;
                  mul_b  <= ONE;
                  mul_go <= 1'b1;
                  state  <= ST_POST;
               end else begin
                  state <= ST_LOOP;
               end
            end
            ST_LOOP: begin
               sq_a   <= p_q;
               sq_b   <= p_q;
               sq_go  <= 1'b1;
               mul_a  <= a_q;
               mul_b  <= p_q;
               mul_go <= e_q[0];
               sq_ok  <= 1'b0;
               mul_ok <= ~e_q[0];
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (sq_done) begin
                  sq_ok <= 1'b1;
                  p_q   <= sq_res;
               end
               if (mul_done) begin
                  mul_ok <= 1'b1;
                  a_q    <= mul_res;
               end
               if (both) begin
                  e_q <= e_q >> 1;
                  rem <= rem - LEN_W'(1);
                  if (rem == LEN_W'(1)) begin
                     mul_a  <= a_next;
                     mul_b  <= ONE;
                     mul_go <= 1'b1;
                     state  <= ST_POST;
                  end else begin
                     state <= ST_LOOP;
                  end
               end
            end
            // cnt covers accept..now-1; +2 adds this cycle and the done cycle
            ST_POST: if (mul_done) begin
               result <= mul_res;
               done   <= 1'b1;
               busy   <= 1'b0;
               cycles <= sat_add32(cnt, 32'd2);
               state  <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_exp_par.sv
// Scoreboard bench for mod_exp_par at WIDTH=8, n=0xB3.
`timescale 1ns/1ps
module tb_mod_exp_par;
   import rsa_pkg::*;

   localparam int W  = 8;
   localparam int EW = 16;
   localparam int LW = 5;
   localparam logic [W-1:0] N   = 8'hB3;
   localparam logic [W-1:0] RN  = 8'h4D;
   localparam logic [W-1:0] R2N = 8'h16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  x = '0;
   logic [EW-1:0] e = '0;
   logic [LW-1:0] e_len = '0;
   logic          busy, done;
   logic [W-1:0]  result;
   logic [31:0]   cycles;

   typedef struct {
      logic [W-1:0] res;
      int           c0;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n = 0;
   int   done_n = 0;
   int   sq_n = 0;
   int   mul_n = 0;
   int   loop_n = 0;
   logic prev_done = 1'b0;

   mod_exp_par #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .x      (x),
      .e      (e),
      .e_len  (e_len),
      .n      (N),
      .r_n    (RN),
      .r2_n   (R2N),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cycles (cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [W-1:0] ref_exp(input logic [W-1:0] b,
                                            input logic [EW-1:0] ex,
                                            input int len);
      longint r = 1;
      longint p = longint'(b);
      longint m = longint'(N);
      int     l = (len > EW) ? EW : len;
      for (int i = 0; i < l; i++) begin
         if (ex[i]) r = (r * p) % m;
         p = (p * p) % m;
      end
      return W'(r);
   endfunction

   always @(posedge clk) edge_n <= edge_n + 1;

   always @(negedge clk) begin
      if (resetn) begin
         if (dut.state == ST_WAIT && dut.sq_go)  sq_n  <= sq_n + 1;
         if (dut.state == ST_WAIT && dut.mul_go) mul_n <= mul_n + 1;
         if (dut.state == ST_LOOP)               loop_n <= loop_n + 1;
         if (done) begin
            done_n <= done_n + 1;
            chk("done_width", 64'(prev_done), 64'd0);
            if (sb_q.size() == 0) begin
               chk("spurious_done", 64'd1, 64'd0);
            end else begin
               chk("result", 64'(result), 64'(sb_q[0].res));
               chk("cycles", 64'(cycles), 64'(edge_n - sb_q[0].c0 + 2));
               void'(sb_q.pop_front());
            end
         end
      end
      prev_done <= done;
   end

   task automatic run_op(input logic [W-1:0] xi, input logic [EW-1:0] ei,
                         input int li, input logic [W-1:0] want);
      exp_t t;
      x      = xi;
      e      = ei;
      e_len  = LW'(li);
      start  = 1'b1;
      t.res  = want;
      t.c0   = edge_n + 1;
      sb_q.push_back(t);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sb_q.size() != 0 && k < 4000) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (sb_q.size() != 0) begin
         chk("timeout", 64'd1, 64'd0);
         sb_q.delete();
      end
      @(negedge clk);
      #1;
   endtask

   initial begin
      int s0, m0, l0, d0, k;
      logic [W-1:0]  rx;
      logic [EW-1:0] re;
      int            rl;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_cycles", 64'(cycles), 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      #1;

      d0 = done_n;
      run_op(8'h05, 16'h3, 2, 8'h7D);
      wait_idle();
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("one_done", 64'(done_n - d0), 64'd1);

      s0 = sq_n;
      m0 = mul_n;
      run_op(8'h02, 16'hD, 4, 8'h89);
      wait_idle();
      chk("mul_starts", 64'(mul_n - m0), 64'd3);
      chk("sq_starts", 64'(sq_n - s0), 64'd4);

      l0 = loop_n;
      run_op(8'h05, 16'h3, 0, 8'h01);
      wait_idle();
      chk("no_loop", 64'(loop_n - l0), 64'd0);

      d0 = done_n;
      run_op(8'h00, 16'h5, 3, 8'h00);
      repeat (3) @(negedge clk);
      x     = 8'h33;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      chk("busy_start_ignored", 64'(done_n - d0), 64'd1);

      run_op(8'h05, 16'h3, 2, 8'h7D);
      k = 0;
      while (!done && k < 4000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("done_seen", 64'(done), 64'd1);
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      chk("start_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      #1;
      chk("still_idle", 64'(busy), 64'd0);

      run_op(8'h05, 16'h3, 2, 8'h7D);
      k = 0;
      while (dut.state != ST_WAIT && k < 4000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("reached_wait", 64'(dut.state == ST_WAIT), 64'd1);
      d0 = done_n;
      resetn = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      sb_q.delete();
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("no_done_after_abort", 64'(done_n - d0), 64'd0);
      run_op(8'h05, 16'h3, 2, 8'h7D);
      wait_idle();

      run_op(8'h07, {EW{1'b1}}, EW, ref_exp(8'h07, {EW{1'b1}}, EW));
      wait_idle();
      run_op(8'h07, {EW{1'b1}}, 20, ref_exp(8'h07, {EW{1'b1}}, 20));
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         rx = W'($urandom_range(0, 178));
         re = EW'($urandom);
         rl = int'($urandom_range(1, EW));
         run_op(rx, re, rl, ref_exp(rx, re, rl));
         wait_idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
